// File: rtl/mode_select_ctrl.sv
// Mode selector: debounced Next/Prev keys step a wrap-around Selector.
// Ports: Clock, Reset(async low), KeyNext/KeyPrev(raw active-low), AutoMode -> Selector[7:0], Changed.
// Optional auto-advance timer enabled by defining AUTO_CYCLE_EN.
module mode_select_ctrl #(
  parameter int NUM_MODES       = 8,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int AUTO_PERIOD     = 250000000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       KeyNext,
  input  logic       KeyPrev,
  input  logic       AutoMode,
  output logic [7:0] Selector,
  output logic       Changed
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] SMAX = 8'(NUM_MODES - 1);

  typedef enum logic {
    RELEASED = 1'b0,
    PRESSED  = 1'b1
  } key_st_t;

  // bit 0 = Next, bit 1 = Prev
  logic [1:0]    raw;
  logic [1:0]    s1;
  logic [1:0]    s2;
  logic [1:0]    deb;
  logic [1:0]    strobe;
  logic [DW-1:0] cnt [2];
  key_st_t       st [2];
  key_st_t       st_nx [2];

  assign raw = {KeyPrev, KeyNext};

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      s1     <= '1;
      s2     <= '1;
      deb    <= '1;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      for (int k = 0; k < 2; k++) begin
        if (s2[k] == deb[k]) begin
          cnt[k] <= '0;
        end else if (cnt[k] == DMAX) begin
          deb[k] <= s2[k];
          cnt[k] <= '0;
        end else begin
          cnt[k] <= cnt[k] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      st[0] <= RELEASED;
      st[1] <= RELEASED;
    end else begin
      st[0] <= st_nx[0];
      st[1] <= st_nx[1];
    end
  end

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      st_nx[k] = st[k];
      unique case (st[k])
        RELEASED: if (!deb[k]) st_nx[k] = PRESSED;
        PRESSED:  if (deb[k])  st_nx[k] = RELEASED;
      endcase
    end
  end

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      strobe[k] = (st[k] == RELEASED) && !deb[k];
    end
  end

  logic any_press;
  logic do_next;
  logic do_prev;
  logic do_auto;

  assign any_press = |strobe;
  assign do_next   = strobe[0] & ~strobe[1];
  assign do_prev   = strobe[1] & ~strobe[0];

`ifdef AUTO_CYCLE_EN
  localparam int TW = $clog2(AUTO_PERIOD + 1);
  localparam logic [TW-1:0] TMAX = TW'(AUTO_PERIOD - 1);

  logic [TW-1:0] timer;
  logic          expire;

  assign expire = AutoMode && (timer == TMAX);
  // a manual press (even a cancelling double press) pre-empts expiry
  assign do_auto = expire & ~any_press;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      timer <= '0;
    end else if (!AutoMode || any_press || expire) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end
`else
  logic unused_auto;

  assign unused_auto = AutoMode;
  assign do_auto     = 1'b0;
`endif

  logic [7:0] sel_nx;
  logic       chg_nx;

  always_comb begin
    sel_nx = Selector;
    chg_nx = 1'b0;
    unique case (1'b1)
      do_next, do_auto: begin
        sel_nx = (Selector == SMAX) ? 8'd0 : Selector + 8'd1;
        chg_nx = 1'b1;
      end
      do_prev: begin
        sel_nx = (Selector == 8'd0) ? SMAX : Selector - 8'd1;
        chg_nx = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      Selector <= 8'd0;
      Changed  <= 1'b0;
    end else begin
      Selector <= sel_nx;
      Changed  <= chg_nx;
    end
  end

endmodule

// File: tb/tb_mode_select_ctrl.sv
// Testbench for mode_select_ctrl: directed steps plus random key traffic
// checked against an arithmetic mode-index model.
module tb_mode_select_ctrl;

  localparam int N   = 8;
  localparam int DEB = 4;
  localparam int AP  = 20;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       KeyNext = 1'b1;
  logic       KeyPrev = 1'b1;
  logic       AutoMode = 1'b0;
  logic [7:0] Selector;
  logic       Changed;

  int passed = 0;
  int total = 0;
  int pulses = 0;
  int bad_range = 0;
  int model = 0;

  mode_select_ctrl #(
    .NUM_MODES(N),
    .DEBOUNCE_CYCLES(DEB),
    .AUTO_PERIOD(AP)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .KeyNext(KeyNext),
    .KeyPrev(KeyPrev),
    .AutoMode(AutoMode),
    .Selector(Selector),
    .Changed(Changed)
  );

  always #5 Clock = ~Clock;

  always @(negedge Clock) begin
    if (Changed === 1'b1) pulses++;
    if (Reset && !(Selector < 8'(N))) bad_range++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic press(input bit n, input bit p, input int len,
                       input int gap);
    KeyNext = ~n;
    KeyPrev = ~p;
    tick(len);
    KeyNext = 1'b1;
    KeyPrev = 1'b1;
    tick(gap);
  endtask

  initial begin
    int p0;
    int kind;
    int len;

    tick(2);
    check("reset_sel", 32'(Selector), 0);
    check("reset_chg", 32'(Changed), 0);
    Reset = 1'b1;
    tick(2);

    p0 = pulses;
    press(1, 0, 2, 15);
    check("glitch2_sel", 32'(Selector), 0);
    check("glitch2_pulses", pulses - p0, 0);

    p0 = pulses;
    KeyNext = 1'b0;
    tick(6);
    check("lat_before", 32'(Selector), 0);
    tick(1);
    check("lat_sel", 32'(Selector), 1);
    check("lat_chg", 32'(Changed), 1);
    tick(1);
    check("lat_chg_drop", 32'(Changed), 0);
    tick(22);
    check("hold_norepeat_sel", 32'(Selector), 1);
    check("hold_pulses", pulses - p0, 1);
    KeyNext = 1'b1;
    tick(12);
    press(1, 0, 8, 12);
    check("second_press", 32'(Selector), 2);

    Reset = 1'b0;
    tick(1);
    Reset = 1'b1;
    tick(1);
    model = 0;
    for (int i = 1; i <= 8; i++) begin
      press(1, 0, 6, 12);
      model = i % N;
      check($sformatf("next_%0d", i), 32'(Selector), 32'(model));
    end
    press(0, 1, 6, 12);
    model = N - 1;
    check("prev_wrap", 32'(Selector), 32'(model));

    p0 = pulses;
    press(1, 1, 10, 14);
    check("both_sel", 32'(Selector), 32'(model));
    check("both_pulses", pulses - p0, 0);

    while (model != 5) begin
      press(1, 0, 6, 12);
      model = (model + 1) % N;
    end
    check("at_five", 32'(Selector), 5);
    KeyNext = 1'b0;
    tick(3);
    Reset = 1'b0;
    #1;
    check("async_reset", 32'(Selector), 0);
    tick(1);
    Reset = 1'b1;
    tick(6);
    check("post_reset_wait", 32'(Selector), 0);
    tick(1);
    check("post_reset_press", 32'(Selector), 1);
    KeyNext = 1'b1;
    tick(14);
    model = 1;

    for (int i = 0; i < 24; i++) begin
      kind = $urandom_range(0, 2);
      len  = ($urandom_range(0, 1) != 0) ? $urandom_range(DEB, 12)
                                         : $urandom_range(1, DEB - 1);
      p0 = pulses;
      press(kind != 1, kind != 0, len, 14);
      if (len >= DEB && kind == 0) model = (model + 1) % N;
      if (len >= DEB && kind == 1) model = (model + N - 1) % N;
      check($sformatf("rnd%0d_k%0d_l%0d_sel", i, kind, len),
            32'(Selector), 32'(model));
      check($sformatf("rnd%0d_pulses", i), pulses - p0,
            (len >= DEB && kind != 2) ? 1 : 0);
    end

`ifdef AUTO_CYCLE_EN
    AutoMode = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(AP - 1);
      check($sformatf("auto%0d_hold", i), 32'(Selector), 32'(model));
      tick(1);
      model = (model + 1) % N;
      check($sformatf("auto%0d_step", i), 32'(Selector), 32'(model));
    end
    tick(9);
    KeyPrev = 1'b0;
    tick(6);
    check("auto_prev_wait", 32'(Selector), 32'(model));
    tick(1);
    model = (model + N - 1) % N;
    check("auto_prev", 32'(Selector), 32'(model));
    tick(3);
    KeyPrev = 1'b1;
    tick(16);
    check("auto_after_prev_hold", 32'(Selector), 32'(model));
    tick(1);
    model = (model + 1) % N;
    check("auto_after_prev", 32'(Selector), 32'(model));
    AutoMode = 1'b0;
    tick(2);
`endif

    check("range", bad_range, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
